dmem_arbiter: RTL

Two-requester arbiter that shares the SoC's single data-memory port (the bootram/mainmem data-side bus) between the hart and a second bus master (debug loader or DMA). It arbitrates per transfer with round-robin fairness, supports locked back-to-back sequences with a bounded hold, and routes synchronous read data back to the master that issued the read. It sits between the masters' data ports and the memory chip-select/decode fabric.

---
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares the single data-memory port between two bus masters (m0 = hart,
//   m1 = debug loader / DMA). Arbitration is per transfer, combinational and
//   round-robin. A master can hold the port with a bounded lock. Read data
//   (one cycle after the command) is steered back to the master that issued
//   the read.
//
// Ports:
//   clk, rst                 system clock; asynchronous active-low reset
//   m<i>_req/lock/rd         request, lock-next-grant, read strobe
//   m<i>_wr[3:0]             byte write enables (a write beats rd)
//   m<i>_addr/wdata[31:0]    byte address, write data
//   m<i>_gnt                 command issued to memory this cycle
//   m<i>_rvalid/rdata[31:0]  returned read data (rdata is 0 when not valid)
//   mem_rd/wr/addr/wdata     shared memory command (all 0 with no grant)
//   mem_rdata[31:0]          memory read data, one cycle after mem_rd
//
// Parameters:
//   MAX_LOCK                 max consecutive locked grants while the other
//                            master is waiting (1..15)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_rd,
  input  logic [3:0]  m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_rd,
  input  logic [3:0]  m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_rd,
  output logic [3:0]  mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LockMax = 4'(MAX_LOCK);

  logic       last_q, last_d;
  logic       lock_vld_q, lock_vld_d;
  logic       lock_own_q, lock_own_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_who_q, rd_who_d;

  logic [1:0]  req;
  logic [1:0]  lock_in;
  logic        gnt_any;
  logic        win;
  logic        rd_w;
  logic [3:0]  wr_w;
  logic [31:0] addr_w;
  logic [31:0] wdata_w;
  logic [3:0]  cnt_base;

  assign req     = {m1_req, m0_req};
  assign lock_in = {m1_lock, m0_lock};

  // Winner selection. rst low suppresses every grant.
  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_any = 1'b0;
    win     = 1'b0;
    if (!rst) begin
      gnt_any = 1'b0;
    end else if (lock_vld_q && req[lock_own_q]) begin
      gnt_any = 1'b1;
      // Lock bound reached with the other master waiting: hand over.
      if (req[~lock_own_q] && (lock_cnt_q == LockMax)) begin
        win = ~lock_own_q;
      end else begin
        win = lock_own_q;
      end
    end else if (req == 2'b11) begin
      gnt_any = 1'b1;
      win     = ~last_q;
    end else if (req[0]) begin
      gnt_any = 1'b1;
      win     = 1'b0;
    end else if (req[1]) begin
      gnt_any = 1'b1;
      win     = 1'b1;
    end
  end

  assign rd_w    = win ? m1_rd    : m0_rd;
  assign wr_w    = win ? m1_wr    : m0_wr;
  assign addr_w  = win ? m1_addr  : m0_addr;
  assign wdata_w = win ? m1_wdata : m0_wdata;

  // Command mux: a write (any byte enable) suppresses a simultaneous read.
  assign mem_rd    = gnt_any & rd_w & (wr_w == 4'h0);
  assign mem_wr    = gnt_any ? wr_w    : 4'h0;
  assign mem_addr  = gnt_any ? addr_w  : 32'h0;
  assign mem_wdata = gnt_any ? wdata_w : 32'h0;

  assign m0_gnt = gnt_any & ~win;
  assign m1_gnt = gnt_any &  win;

  // Next-state for round-robin pointer, lock tracking and read return.
  always_comb begin
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    cnt_base   = 4'h0;
    rd_pend_d  = mem_rd;
    rd_who_d   = win;
    if (gnt_any) begin
      last_d = win;
      if (lock_in[win]) begin
        lock_vld_d = 1'b1;
        lock_own_d = win;
        if (req[~win]) begin
          // Continue counting only when the same owner keeps its lock;
          // a fresh or handed-over lock starts from zero.
          cnt_base   = (lock_vld_q && (lock_own_q == win)) ? lock_cnt_q : 4'h0;
          lock_cnt_d = (cnt_base >= LockMax) ? LockMax : cnt_base + 4'h1;
        end else begin
          lock_cnt_d = 4'h0;
        end
      end else begin
        lock_vld_d = 1'b0;
        lock_cnt_d = 4'h0;
      end
    end else if (lock_vld_q && !req[lock_own_q]) begin
      lock_vld_d = 1'b0;
      lock_cnt_d = 4'h0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= 4'h0;
      rd_pend_q  <= 1'b0;
      rd_who_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_who_q   <= rd_who_d;
    end
  end

  assign m0_rvalid = rst & rd_pend_q & ~rd_who_q;
  assign m1_rvalid = rst & rd_pend_q &  rd_who_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule
